// File: rtl/mem_srv.sv
// Byte-request responder for a 16-bit async SRAM/PSRAM: edge-detects mapper strobes, holds one pending slot, runs timed chip cycles.
// Optional write protection of page WP_PAGE is enabled by defining MEM_WR_PROTECT_EN.
module mem_srv #(
    parameter int         RD_CYC  = 4,
    parameter int         WR_CYC  = 4,
    parameter int         REC_CYC = 1,
    parameter logic [6:0] WP_PAGE = 7'h7f
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_ce,
    input  logic        req_oe,
    input  logic        req_we,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_dati,
    output logic [7:0]  req_dato,
    output logic        busy,
    output logic [22:0] mem_addr,
    input  logic [15:0] mem_dq_i,
    output logic [15:0] mem_dq_o,
    output logic        mem_dq_oe,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic        mem_ub_n,
    output logic        mem_lb_n
);

    typedef enum logic [1:0] {IDLE, RD, WR, REC} state_t;

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        lane, lane_nx;
    logic        rd_prev, wr_prev, rd_req, wr_req;
    logic        slot_vld, slot_wr, slot_take, slot_wp;
    logic [23:0] slot_addr;
    logic [7:0]  slot_dati;
    logic [22:0] addr_nx;
    logic [15:0] dq_o_nx;
    logic [7:0]  dato_nx;
    logic        dq_oe_nx, ce_n_nx, oe_n_nx, we_n_nx, ub_n_nx, lb_n_nx;

    // A write edge in the same cycle as a read edge wins; the read is dropped.
    assign rd_req    = req_ce & req_oe & ~rd_prev;
    assign wr_req    = req_ce & req_we & ~wr_prev;
    assign slot_take = (state == IDLE) && slot_vld;
    assign busy      = slot_vld || (state != IDLE);

`ifdef MEM_WR_PROTECT_EN
    assign slot_wp = (slot_addr[23:17] == WP_PAGE);
`else
    logic wp_unused;
    assign slot_wp   = 1'b0;
    assign wp_unused = ^WP_PAGE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_prev   <= 1'b0;
            wr_prev   <= 1'b0;
            slot_vld  <= 1'b0;
            slot_wr   <= 1'b0;
            slot_addr <= '0;
            slot_dati <= '0;
        end else begin
            rd_prev <= req_ce & req_oe;
            wr_prev <= req_ce & req_we;
            if (rd_req || wr_req) begin
                slot_vld  <= 1'b1;
                slot_wr   <= wr_req;
                slot_addr <= req_addr;
                slot_dati <= req_dati;
            end else if (slot_take) begin
                slot_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lane      <= 1'b0;
            mem_addr  <= '0;
            mem_dq_o  <= '0;
            mem_dq_oe <= 1'b0;
            mem_ce_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            mem_ub_n  <= 1'b1;
            mem_lb_n  <= 1'b1;
            req_dato  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            lane      <= lane_nx;
            mem_addr  <= addr_nx;
            mem_dq_o  <= dq_o_nx;
            mem_dq_oe <= dq_oe_nx;
            mem_ce_n  <= ce_n_nx;
            mem_oe_n  <= oe_n_nx;
            mem_we_n  <= we_n_nx;
            mem_ub_n  <= ub_n_nx;
            mem_lb_n  <= lb_n_nx;
            req_dato  <= dato_nx;
        end
    end

    // Outside WR the data bus defaults off, which also gives the one-cycle hold after a write.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        lane_nx  = lane;
        addr_nx  = mem_addr;
        dq_o_nx  = mem_dq_o;
        dq_oe_nx = 1'b0;
        ce_n_nx  = mem_ce_n;
        oe_n_nx  = mem_oe_n;
        we_n_nx  = mem_we_n;
        ub_n_nx  = mem_ub_n;
        lb_n_nx  = mem_lb_n;
        dato_nx  = req_dato;
        unique case (state)
            IDLE: begin
                if (slot_vld) begin
                    addr_nx = slot_addr[23:1];
                    lane_nx = slot_addr[0];
                    ce_n_nx = 1'b0;
                    lb_n_nx = slot_addr[0];
                    ub_n_nx = ~slot_addr[0];
                    cnt_nx  = '0;
                    if (slot_wr) begin
                        state_nx = WR;
                        dq_o_nx  = {slot_dati, slot_dati};
                        dq_oe_nx = ~slot_wp;
                        we_n_nx  = slot_wp;
                    end else begin
                        state_nx = RD;
                        oe_n_nx  = 1'b0;
                    end
                end
            end
            RD: begin
                if (cnt == 8'(RD_CYC - 1)) begin
                    dato_nx  = lane ? mem_dq_i[15:8] : mem_dq_i[7:0];
                    ce_n_nx  = 1'b1;
                    oe_n_nx  = 1'b1;
                    ub_n_nx  = 1'b1;
                    lb_n_nx  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = (REC_CYC == 0) ? IDLE : REC;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            WR: begin
                dq_oe_nx = mem_dq_oe;
                if (cnt == 8'(WR_CYC - 1)) begin
                    ce_n_nx  = 1'b1;
                    we_n_nx  = 1'b1;
                    ub_n_nx  = 1'b1;
                    lb_n_nx  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = (REC_CYC == 0) ? IDLE : REC;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            REC: begin
                if (cnt == 8'(REC_CYC - 1)) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_srv.sv
// Scoreboard bench for mem_srv: stimulus pushes expected chip accesses, a negedge monitor pops and checks each completed access.
module tb_mem_srv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_ce = 1'b0, req_oe = 1'b0, req_we = 1'b0;
    logic [23:0] req_addr = '0;
    logic [7:0]  req_dati = '0;
    logic [15:0] mem_dq_i = '0;
    logic [7:0]  req_dato;
    logic        busy;
    logic [22:0] mem_addr;
    logic [15:0] mem_dq_o;
    logic        mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n;

    always #5 clk = ~clk;

    mem_srv dut (
        .clk(clk), .rst(rst),
        .req_ce(req_ce), .req_oe(req_oe), .req_we(req_we),
        .req_addr(req_addr), .req_dati(req_dati), .req_dato(req_dato),
        .busy(busy), .mem_addr(mem_addr),
        .mem_dq_i(mem_dq_i), .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe),
        .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .mem_ub_n(mem_ub_n), .mem_lb_n(mem_lb_n)
    );

    typedef struct {
        logic        wr;
        logic        prot;
        logic [22:0] waddr;
        logic        ub_n;
        logic        lb_n;
        int          oe_cyc;
        int          we_cyc;
        int          dqoe_cyc;
        logic        hold;
        logic [15:0] dq_o;
        logic [7:0]  dato;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0, passes = 0;
    int          acc_count = 0, busy_run = 0, last_busy_len = 0;
    logic [7:0]  last_dato = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_rd(input logic [23:0] a);
        exp_t e;
        e.wr = 1'b0; e.prot = 1'b0; e.waddr = a[23:1];
        e.ub_n = ~a[0]; e.lb_n = a[0];
        e.oe_cyc = 4; e.we_cyc = 0; e.dqoe_cyc = 0; e.hold = 1'b0;
        e.dq_o = '0;
        e.dato = a[0] ? mem_dq_i[15:8] : mem_dq_i[7:0];
        last_dato = e.dato;
        q.push_back(e);
    endtask

    task automatic push_wr(input logic [23:0] a, input logic [7:0] d, input logic prot);
        exp_t e;
        e.wr = 1'b1; e.prot = prot; e.waddr = a[23:1];
        e.ub_n = ~a[0]; e.lb_n = a[0];
        e.oe_cyc = 0; e.we_cyc = prot ? 0 : 4; e.dqoe_cyc = prot ? 0 : 4;
        e.hold = ~prot; e.dq_o = {d, d}; e.dato = last_dato;
        q.push_back(e);
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [23:0] a,
                         input logic [7:0] d, input int hold_cyc);
        @(posedge clk); #1;
        req_addr = a; req_dati = d; req_ce = 1'b1; req_oe = rd; req_we = wr;
        repeat (hold_cyc) @(posedge clk);
        #1;
        req_ce = 1'b0; req_oe = 1'b0; req_we = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || !mem_ce_n || q.size() != 0) && n < 400);
        check({name, "_done"}, 32'(n < 400), 32'd1);
        @(negedge clk);
    endtask

    logic        in_acc = 1'b0, chk_drop = 1'b0;
    int          ce_c, oe_c, we_c, dqoe_c;
    logic [22:0] a_s;
    logic        ub_s, lb_s;
    logic [15:0] dq_s;

    always @(negedge clk) begin
        if (rst) begin
            in_acc   = 1'b0;
            chk_drop = 1'b0;
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            else if (busy_run > 0) begin
                last_busy_len = busy_run;
                busy_run = 0;
            end
            if (chk_drop) begin
                check("dq_oe_release", 32'(mem_dq_oe), 32'd0);
                chk_drop = 1'b0;
            end
            if (!mem_ce_n) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    ce_c = 0; oe_c = 0; we_c = 0; dqoe_c = 0;
                    a_s = mem_addr; ub_s = mem_ub_n; lb_s = mem_lb_n; dq_s = mem_dq_o;
                end
                ce_c++;
                if (!mem_oe_n) oe_c++;
                if (!mem_we_n) we_c++;
                if (mem_dq_oe) dqoe_c++;
            end else if (in_acc) begin
                in_acc = 1'b0;
                acc_count++;
                check("access_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    check("acc_addr", 32'(a_s), 32'(mon_e.waddr));
                    check("acc_lanes", 32'({ub_s, lb_s}), 32'({mon_e.ub_n, mon_e.lb_n}));
                    check("acc_ce_cyc", 32'(ce_c), 32'd4);
                    check("acc_oe_cyc", 32'(oe_c), 32'(mon_e.oe_cyc));
                    check("acc_we_cyc", 32'(we_c), 32'(mon_e.we_cyc));
                    check("acc_dqoe_cyc", 32'(dqoe_c), 32'(mon_e.dqoe_cyc));
                    check("acc_dato", 32'(req_dato), 32'(mon_e.dato));
                    check("acc_dq_oe_hold", 32'(mem_dq_oe), 32'(mon_e.hold));
                    if (mon_e.wr && !mon_e.prot) check("acc_dq_o", 32'(dq_s), 32'(mon_e.dq_o));
                    if (mon_e.hold) chk_drop = 1'b1;
                end
            end
        end
    end

    initial begin
        int n0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n}), 32'h1f);
        check("rst_oe_busy", 32'({mem_dq_oe, busy}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_dq_o", 32'(mem_dq_o), 32'd0);
        check("rst_dato", 32'(req_dato), 32'd0);
        #2 rst = 1'b0;

        // Read with latency checks: lane 1 of 16'hA55A.
        mem_dq_i = 16'hA55A;
        push_rd(24'h000003);
        @(posedge clk); #1;
        req_addr = 24'h000003; req_ce = 1'b1; req_oe = 1'b1;
        @(posedge clk); #1;
        req_ce = 1'b0; req_oe = 1'b0;
        @(negedge clk);
        check("ce_not_yet", 32'(mem_ce_n), 32'd1);
        check("busy_after_detect", 32'(busy), 32'd1);
        @(negedge clk);
        check("ce_latency", 32'(mem_ce_n), 32'd0);
        repeat (3) @(negedge clk);
        check("dato_before_done", 32'(req_dato), 32'd0);
        @(negedge clk);
        check("read_latency", 32'(req_dato), 32'hA5);
        wait_idle("read1");
        check("read1_busy_len", 32'(last_busy_len), 32'd6);

        // Reset in the middle of a read abandons it.
        mem_dq_i = 16'h6699;
        issue(1'b1, 1'b0, 24'h000020, 8'h00, 1);
        repeat (2) @(negedge clk);
        check("rd_started", 32'(mem_oe_n), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n}), 32'h1f);
        check("midrst_oe_busy", 32'({mem_dq_oe, busy}), 32'd0);
        check("midrst_dato", 32'(req_dato), 32'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        last_dato = 8'h00;
        mem_dq_i = 16'h5AC3;
        push_rd(24'h000021);
        issue(1'b1, 1'b0, 24'h000021, 8'h00, 1);
        wait_idle("read_after_rst");

        // Byte write, lane 0.
        push_wr(24'h000010, 8'h3C, 1'b0);
        issue(1'b0, 1'b1, 24'h000010, 8'h3C, 1);
        wait_idle("write1");
        check("write1_busy_len", 32'(last_busy_len), 32'd6);

        // Two reads arrive during an active read: last one wins.
        mem_dq_i = 16'h1234;
        n0 = acc_count;
        push_rd(24'h000100);
        push_rd(24'h000004);
        issue(1'b1, 1'b0, 24'h000100, 8'h00, 1);
        issue(1'b1, 1'b0, 24'h000002, 8'h00, 1);
        issue(1'b1, 1'b0, 24'h000004, 8'h00, 1);
        wait_idle("queued");
        check("queued_busy_len", 32'(last_busy_len), 32'd12);
        check("queued_accesses", 32'(acc_count - n0), 32'd2);

        // Simultaneous read and write edges: write only.
        push_wr(24'h000041, 8'h77, 1'b0);
        issue(1'b1, 1'b1, 24'h000041, 8'h77, 1);
        wait_idle("simul");

        // Strobe held for 20 cycles produces one access.
        mem_dq_i = 16'hBEEF;
        n0 = acc_count;
        push_rd(24'h000007);
        issue(1'b1, 1'b0, 24'h000007, 8'h00, 20);
        wait_idle("held");
        check("held_single_access", 32'(acc_count - n0), 32'd1);

`ifdef MEM_WR_PROTECT_EN
        push_wr(24'hFE0000, 8'h99, 1'b1);
        issue(1'b0, 1'b1, 24'hFE0000, 8'h99, 1);
        wait_idle("wp_page");
        check("wp_busy_len", 32'(last_busy_len), 32'd6);
`else
        push_wr(24'hFE0000, 8'h99, 1'b0);
        issue(1'b0, 1'b1, 24'hFE0000, 8'h99, 1);
        wait_idle("top_page");
        check("top_busy_len", 32'(last_busy_len), 32'd6);
`endif
        push_wr(24'h000000, 8'h42, 1'b0);
        issue(1'b0, 1'b1, 24'h000000, 8'h42, 1);
        wait_idle("page0_write");
        check("page0_busy_len", 32'(last_busy_len), 32'd6);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_srv.md
Name: mem_srv

Overview:
- Responder end of the mapper memory-request interface. Services byte read/write requests (ce/oe/we/addr/dati) from the mapper against an external 16-bit asynchronous SRAM/PSRAM, and returns read data on dato.
- One instance per memory (ROM chip, RAM chip). Sits between the mapper outputs and the cartridge memory pins.
- Turns level-style request strobes into a timed chip access with a single pending-request slot.

Parameters:
- RD_CYC, 4, clk cycles mem_oe_n held low before read data is sampled (min 1).
- WR_CYC, 4, clk cycles mem_we_n held low (min 1).
- REC_CYC, 1, idle cycles with all strobes high between accesses (min 0).
- WP_PAGE, 7'h7f, addr[23:17] page protected when MEM_WR_PROTECT_EN is defined.

Ports:
- clk  in  1  system clock; req_* inputs are already synchronous to clk.
- rst  in  1  reset, asynchronous, active-high.
- req_ce  in  1  request targets this memory.
- req_oe  in  1  read strobe.
- req_we  in  1  write strobe.
- req_addr  in  24  byte address.
- req_dati  in  8  write data.
- req_dato  out  8  last read byte, held stable until the next read completes.
- busy  out  1  access in progress or pending.
- mem_addr  out  23  word address = addr[23:1].
- mem_dq_i  in  16  memory data in.
- mem_dq_o  out  16  memory data out.
- mem_dq_oe  out  1  data bus drive enable.
- mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n  out  1 each  active-low chip controls.

Behaviour:
- Reset (async):
  - state=IDLE; all mem_*_n=1; mem_dq_oe=0; mem_addr=0; mem_dq_o=0; req_dato=0; busy=0; pending slot cleared.
  - Reset asserted mid-access drops all strobes in the same instant; the access is abandoned with no completion.
- Request detection:
  - rd_req = rising edge of (req_ce & req_oe); wr_req = rising edge of (req_ce & req_we). Edge is taken against the registered previous value.
  - Both edges in the same cycle: write only; the read is dropped.
  - Held strobes do not retrigger.
- Request capture: on detection, latch addr, dati and type into the pending slot.
  - If the slot is already full, the newer request overwrites it (last-wins).
  - busy=1 from the cycle after detection until the FSM returns to IDLE with the slot empty.
- FSM states: IDLE, RD, WR, REC.
  - IDLE:
    - Slot full: load mem_addr=addr[23:1] and assert mem_ce_n=0. Byte lane is addr[0]: 0 -> mem_lb_n=0, 1 -> mem_ub_n=0; the other lane stays 1.
    - Read -> RD with mem_oe_n=0.
    - Write -> WR with mem_dq_o={dati,dati}, mem_dq_oe=1, mem_we_n=0.
    - The slot clears on the transition.
  - RD: count RD_CYC cycles. On the last cycle register the selected byte (lane 0 -> dq_i[7:0], lane 1 -> dq_i[15:8]) into req_dato, deassert all strobes, go to REC.
  - WR: count WR_CYC cycles, then deassert mem_we_n, mem_ce_n and lanes. mem_dq_oe stays 1 for one further cycle (data hold), then drops. Go to REC.
  - REC: REC_CYC cycles all strobes high, then IDLE. With REC_CYC=0, REC is skipped.
- Detection to mem_ce_n low: 2 cycles (detection register + IDLE load).
- Read latency, detection to req_dato valid: 2+RD_CYC cycles.
- req_dato changes only on read completion; writes never alter it.
- A request arriving during RD/WR/REC waits in the slot and starts on the next IDLE cycle.
- req_ce low: strobe edges are ignored.

Optional Feature:
- MEM_WR_PROTECT_EN defined: a write whose addr[23:17]==WP_PAGE runs the full WR timing except mem_we_n stays 1 and mem_dq_oe stays 0. The cycle count and busy profile are identical to a real write.
- MEM_WR_PROTECT_EN undefined: all writes are performed; WP_PAGE is unused.

Test Plan:
- Reset values: assert rst mid-RD -> all mem_*_n=1, dq_oe=0, req_dato=0, busy=0 in the same cycle. After release, the next read is serviced normally.
- Read at addr 24'h000003, mem_dq_i=16'hA55A, defaults -> mem_addr=23'h000001, ub_n=0, lb_n=1, oe_n low 4 cycles, req_dato=8'hA5 exactly 6 cycles after detection.
- Write 8'h3C to addr 24'h000010 -> mem_addr=23'h000008, lb_n=0, we_n low 4 cycles, dq_o=16'h3C3C, dq_oe drops 1 cycle after we_n rises, req_dato unchanged.
- Two reads queued during an active read (addr 2 then addr 4) -> only addr 4 is serviced after REC; three oe_n pulses never occur; busy stays 1 throughout.
- oe and we edges in the same cycle with req_ce=1 -> single write cycle, no oe_n pulse. Held strobe for 20 cycles -> exactly one access.
- MEM_WR_PROTECT_EN, write to 24'hFE0000 (page 7'h7f) -> we_n stays 1, dq_oe 0, busy high for the same duration as a normal write. Write to 24'h000000 -> performed.
